// File: rtl/phy_tx_arbiter.sv
// Packet-atomic merge of the ordered-set and DLL AXIS streams onto one multi-lane AXIS stream.
// Ordered sets win at boundaries, bounded by a data starvation guard; optional logical-idle fill.
module phy_tx_arbiter #(
  parameter int unsigned MAX_NUM_LANES = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned KEEP_WIDTH    = DATA_WIDTH/8,
  parameter int unsigned USER_WIDTH    = 4,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] s_os_axis_tdata,
  input  logic [MAX_NUM_LANES*KEEP_WIDTH-1:0] s_os_axis_tkeep,
  input  logic [MAX_NUM_LANES*USER_WIDTH-1:0] s_os_axis_tuser,
  input  logic                                s_os_axis_tvalid,
  input  logic                                s_os_axis_tlast,
  output logic                                s_os_axis_tready,
  input  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] s_dl_axis_tdata,
  input  logic [MAX_NUM_LANES*KEEP_WIDTH-1:0] s_dl_axis_tkeep,
  input  logic [MAX_NUM_LANES*USER_WIDTH-1:0] s_dl_axis_tuser,
  input  logic                                s_dl_axis_tvalid,
  input  logic                                s_dl_axis_tlast,
  output logic                                s_dl_axis_tready,
  input  logic                                link_up_i,
  input  logic                                idle_fill_en_i,
  output logic [MAX_NUM_LANES*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [MAX_NUM_LANES*KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [MAX_NUM_LANES*USER_WIDTH-1:0] m_axis_tuser,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  output logic                                os_active_o,
  output logic                                idle_inserted_o
);

  localparam int unsigned TDW = MAX_NUM_LANES * DATA_WIDTH;
  localparam int unsigned TKW = MAX_NUM_LANES * KEEP_WIDTH;
  localparam int unsigned TUW = MAX_NUM_LANES * USER_WIDTH;
  localparam int unsigned CW  = 8;
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_SAT    = '1;

  typedef enum logic [1:0] {ST_ARB, ST_OS, ST_DL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          os_waited_q, os_waited_d;
  logic          ld, dl_elig, grant_os, grant_dl;
  logic          xfer_os, xfer_dl, load_idle, os_waited_now;

  // State, starvation counter and "data was waiting at OS grant" flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_ARB;
      starve_cnt_q <= '0;
      os_waited_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      os_waited_q  <= os_waited_d;
    end
  end

  // Grant, handshake and next-state logic
  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    os_waited_d   = os_waited_q;
    grant_os      = 1'b0;
    grant_dl      = 1'b0;
    os_waited_now = os_waited_q;
    ld            = !m_axis_tvalid || m_axis_tready;
    dl_elig       = s_dl_axis_tvalid && link_up_i;

    case (state_q)
      ST_ARB: begin
        if (s_os_axis_tvalid && ((starve_cnt_q < STARVE_MAX) || !dl_elig)) grant_os = 1'b1;
        else if (dl_elig)                                                   grant_dl = 1'b1;
      end
      ST_OS:   grant_os = 1'b1;
      ST_DL:   grant_dl = 1'b1;
      default: ;
    endcase

    xfer_os   = ld && grant_os && s_os_axis_tvalid;
    xfer_dl   = ld && grant_dl && s_dl_axis_tvalid;
    load_idle = (state_q == ST_ARB) && !grant_os && !grant_dl && idle_fill_en_i && ld;

    if (state_q == ST_ARB) os_waited_now = dl_elig;

    if (xfer_os) begin
      os_waited_d = os_waited_now;
      if (s_os_axis_tlast) begin
        state_d = ST_ARB;
        if (os_waited_now && (starve_cnt_q != CNT_SAT)) starve_cnt_d = starve_cnt_q + CW'(1);
      end else begin
        state_d = ST_OS;
      end
    end else if (xfer_dl) begin
      if (s_dl_axis_tlast) begin
        state_d      = ST_ARB;
        starve_cnt_d = '0;
      end else begin
        state_d = ST_DL;
      end
    end
  end

  assign s_os_axis_tready = ld && grant_os && !rst_i;
  assign s_dl_axis_tready = ld && grant_dl && !rst_i;

  // Output register: granted beat, idle word, or drain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_axis_tdata    <= '0;
      m_axis_tkeep    <= '0;
      m_axis_tuser    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      os_active_o     <= 1'b0;
      idle_inserted_o <= 1'b0;
    end else begin
      os_active_o     <= (state_d == ST_OS);
      idle_inserted_o <= load_idle;
      if (xfer_os) begin
        m_axis_tdata  <= s_os_axis_tdata;
        m_axis_tkeep  <= s_os_axis_tkeep;
        m_axis_tuser  <= s_os_axis_tuser;
        m_axis_tlast  <= s_os_axis_tlast;
        m_axis_tvalid <= 1'b1;
      end else if (xfer_dl) begin
        m_axis_tdata  <= s_dl_axis_tdata;
        m_axis_tkeep  <= s_dl_axis_tkeep;
        m_axis_tuser  <= s_dl_axis_tuser;
        m_axis_tlast  <= s_dl_axis_tlast;
        m_axis_tvalid <= 1'b1;
      end else if (load_idle) begin
        m_axis_tdata  <= TDW'(0);
        m_axis_tkeep  <= {TKW{1'b1}};
        m_axis_tuser  <= TUW'(0);
        m_axis_tlast  <= 1'b1;
        m_axis_tvalid <= 1'b1;
      end else if (ld) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Scoreboard bench for phy_tx_arbiter: per-source expected beat queues, packet atomicity,
// directed arbitration/idle/stall/reset scenarios and a randomized mixed-traffic phase.
module tb_phy_tx_arbiter;

  localparam int unsigned TDW = 128;
  localparam int unsigned TKW = 16;
  localparam int unsigned TUW = 16;

  typedef struct packed {
    logic [TDW-1:0] data;
    logic [TKW-1:0] keep;
    logic [TUW-1:0] user;
    logic           last;
  } beat_t;

  localparam beat_t IDLE_BEAT = {128'h0, 16'hFFFF, 16'h0, 1'b1};

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b0;
  logic [TDW-1:0] s_os_axis_tdata = '0, s_dl_axis_tdata = '0;
  logic [TKW-1:0] s_os_axis_tkeep = '0, s_dl_axis_tkeep = '0;
  logic [TUW-1:0] s_os_axis_tuser = '0, s_dl_axis_tuser = '0;
  logic           s_os_axis_tvalid = 1'b0, s_os_axis_tlast = 1'b0, s_os_axis_tready;
  logic           s_dl_axis_tvalid = 1'b0, s_dl_axis_tlast = 1'b0, s_dl_axis_tready;
  logic           link_up_i = 1'b1, idle_fill_en_i = 1'b0;
  logic [TDW-1:0] m_axis_tdata;
  logic [TKW-1:0] m_axis_tkeep;
  logic [TUW-1:0] m_axis_tuser;
  logic           m_axis_tvalid, m_axis_tlast;
  logic           m_axis_tready = 1'b1;
  logic           os_active_o, idle_inserted_o;

  phy_tx_arbiter #(.MAX_NUM_LANES(4), .DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(4),
                   .STARVE_LIMIT(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_os_axis_tdata(s_os_axis_tdata), .s_os_axis_tkeep(s_os_axis_tkeep),
    .s_os_axis_tuser(s_os_axis_tuser), .s_os_axis_tvalid(s_os_axis_tvalid),
    .s_os_axis_tlast(s_os_axis_tlast), .s_os_axis_tready(s_os_axis_tready),
    .s_dl_axis_tdata(s_dl_axis_tdata), .s_dl_axis_tkeep(s_dl_axis_tkeep),
    .s_dl_axis_tuser(s_dl_axis_tuser), .s_dl_axis_tvalid(s_dl_axis_tvalid),
    .s_dl_axis_tlast(s_dl_axis_tlast), .s_dl_axis_tready(s_dl_axis_tready),
    .link_up_i(link_up_i), .idle_fill_en_i(idle_fill_en_i),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .os_active_o(os_active_o), .idle_inserted_o(idle_inserted_o)
  );

  always #5 clk_i = ~clk_i;

  beat_t os_q[$], dl_q[$];          // beats still to be offered by each source driver
  beat_t exp_os_q[$], exp_dl_q[$];  // beats expected on m_axis, in per-source order
  int    start_q[$];                // source of each packet start seen on m_axis (1=OS, 2=DL)
  int    tests = 0, fails = 0;
  bit    gaps = 1'b0;

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_pkt(input bit os, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data          = {$urandom, $urandom, $urandom, $urandom};
      b.data[127:124] = os ? 4'hA : 4'h5;
      b.keep          = 16'($urandom);
      b.user          = 16'($urandom);
      b.last          = (i == len - 1);
      if (os) begin os_q.push_back(b); exp_os_q.push_back(b); end
      else    begin dl_q.push_back(b); exp_dl_q.push_back(b); end
    end
  endtask

  task automatic wait_hs(input bit os, input int count);
    int seen = 0;
    int n = 0;
    while (seen < count && n < 200) begin
      @(negedge clk_i);
      n++;
      if (os ? (s_os_axis_tvalid && s_os_axis_tready) : (s_dl_axis_tvalid && s_dl_axis_tready))
        seen++;
    end
    check(os ? "os_handshake_timeout" : "dl_handshake_timeout", 192'(seen), 192'(count));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_os_q.size() != 0 || exp_dl_q.size() != 0) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_timeout", 192'(exp_os_q.size() + exp_dl_q.size()), 192'(0));
    repeat (3) @(negedge clk_i);
  endtask

  // OS source driver: offer queue front, advance on handshake seen before the edge
  initial begin : os_drv
    bit xfer;
    forever begin
      @(negedge clk_i);
      xfer = s_os_axis_tvalid && s_os_axis_tready;
      step();
      if (rst_i) begin
        s_os_axis_tvalid = 1'b0;
      end else begin
        if (xfer && os_q.size() != 0) void'(os_q.pop_front());
        if (os_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
          {s_os_axis_tdata, s_os_axis_tkeep, s_os_axis_tuser, s_os_axis_tlast} = os_q[0];
          s_os_axis_tvalid = 1'b1;
        end else begin
          s_os_axis_tvalid = 1'b0;
        end
      end
    end
  end

  initial begin : dl_drv
    bit xfer;
    forever begin
      @(negedge clk_i);
      xfer = s_dl_axis_tvalid && s_dl_axis_tready;
      step();
      if (rst_i) begin
        s_dl_axis_tvalid = 1'b0;
      end else begin
        if (xfer && dl_q.size() != 0) void'(dl_q.pop_front());
        if (dl_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
          {s_dl_axis_tdata, s_dl_axis_tkeep, s_dl_axis_tuser, s_dl_axis_tlast} = dl_q[0];
          s_dl_axis_tvalid = 1'b1;
        end else begin
          s_dl_axis_tvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every presented word with the expected front, pop on handshake
  initial begin : mon
    beat_t act;
    int    in_pkt;
    int    src;
    in_pkt = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        in_pkt = 0;
        continue;
      end
      act = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
      if (idle_inserted_o)
        check("idle_pulse_word", {m_axis_tvalid, act}, {1'b1, IDLE_BEAT});
      if (m_axis_tvalid) begin
        if (act == IDLE_BEAT)               src = 0;
        else if (act.data[127:124] == 4'hA) src = 1;
        else if (act.data[127:124] == 4'h5) src = 2;
        else                                src = 3;
        if (src == 3) check("src_tag", 192'(act.data[127:124]), 192'(4'hA));
        if (src == 1) begin
          if (exp_os_q.size() == 0) check("os_unexpected", 192'(exp_os_q.size()), 192'(1));
          else                      check("os_beat", 192'(act), 192'(exp_os_q[0]));
        end
        if (src == 2) begin
          if (exp_dl_q.size() == 0) check("dl_unexpected", 192'(exp_dl_q.size()), 192'(1));
          else                      check("dl_beat", 192'(act), 192'(exp_dl_q[0]));
        end
        if (m_axis_tready && src == 0) check("idle_mid_packet", 192'(in_pkt), 192'(0));
        if (m_axis_tready && (src == 1 || src == 2)) begin
          check("packet_atomic", 192'(in_pkt == 0 || in_pkt == src), 192'(1));
          if (in_pkt == 0) start_q.push_back(src);
          if (src == 1 && exp_os_q.size() != 0) void'(exp_os_q.pop_front());
          if (src == 2 && exp_dl_q.size() != 0) void'(exp_dl_q.pop_front());
          in_pkt = act.last ? 0 : src;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin : main
    // Reset values
    #1 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_m_axis", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, m_axis_tuser}, '0);
    check("rst_treadys", {s_os_axis_tready, s_dl_axis_tready}, 0);
    check("rst_flags", {os_active_o, idle_inserted_o}, 0);
    @(negedge clk_i);
    #2 rst_i = 1'b0;

    // Lone 4-beat OS packet: one-cycle latency, os_active during beats 1-3
    @(negedge clk_i);
    push_pkt(1'b1, 4);
    wait_hs(1'b1, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("os4_valid_last", {m_axis_tvalid, m_axis_tlast}, {1'b1, (i == 3)});
      check("os4_active", 192'(os_active_o), 192'(i < 3));
      check("os4_dl_ready", 192'(s_dl_axis_tready), 0);
    end
    drain(100);

    // OS arriving mid data packet waits for data tlast
    @(negedge clk_i);
    push_pkt(1'b0, 3);
    wait_hs(1'b0, 1);
    push_pkt(1'b1, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("dl_then_os_tag", {m_axis_tvalid, m_axis_tdata[127:124]},
            {1'b1, (i < 3) ? 4'h5 : 4'hA});
      check("dl_then_os_last", 192'(m_axis_tlast), 192'(i >= 2));
    end
    drain(100);

    // Idle fill on and off
    step();
    idle_fill_en_i = 1'b1;
    @(posedge clk_i);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("idle_word", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast},
            {1'b1, IDLE_BEAT});
      check("idle_pulse", 192'(idle_inserted_o), 1);
    end
    step();
    idle_fill_en_i = 1'b0;
    @(posedge clk_i);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("nofill_idle", {m_axis_tvalid, idle_inserted_o}, 0);
    end

    // Downstream stall mid OS packet
    @(negedge clk_i);
    push_pkt(1'b1, 6);
    wait_hs(1'b1, 2);
    step();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast},
            {1'b1, exp_os_q[0]});
      check("stall_treadys", {s_os_axis_tready, s_dl_axis_tready}, 0);
    end
    step();
    m_axis_tready = 1'b1;
    drain(100);

    // Link down: data never granted
    step();
    link_up_i = 1'b0;
    @(negedge clk_i);
    push_pkt(1'b0, 2);
    begin
      bit seen_rdy = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk_i);
        if (s_dl_axis_tready) seen_rdy = 1'b1;
      end
      check("linkdown_dl_ready", 192'(seen_rdy), 0);
      check("linkdown_dl_pending", 192'(exp_dl_q.size()), 192'(2));
    end
    step();
    link_up_i = 1'b1;
    drain(100);

    // Async reset mid OS packet
    @(negedge clk_i);
    push_pkt(1'b1, 4);
    wait_hs(1'b1, 2);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_m_axis", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 0);
    check("midrst_flags", {os_active_o, idle_inserted_o, s_os_axis_tready, s_dl_axis_tready}, 0);
    os_q.delete();
    exp_os_q.delete();
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    start_q.delete();
    push_pkt(1'b1, 2);
    push_pkt(1'b0, 1);
    drain(100);
    check("restart_count", 192'(start_q.size()), 192'(2));
    if (start_q.size() == 2) check("restart_order", {start_q[0][7:0], start_q[1][7:0]}, {8'd1, 8'd2});

    // Starvation guard: with limit 2, two OS packets then one data packet
    @(negedge clk_i);
    start_q.delete();
    for (int k = 0; k < 8; k++) push_pkt(1'b1, $urandom_range(1, 3));
    for (int k = 0; k < 4; k++) push_pkt(1'b0, $urandom_range(1, 3));
    drain(300);
    check("starve_count", 192'(start_q.size()), 192'(12));
    for (int k = 0; k < 12 && k < start_q.size(); k++)
      check($sformatf("starve_order_%0d", k), 192'(start_q[k]), 192'((k % 3 == 2) ? 2 : 1));

    // Randomized mixed traffic
    gaps = 1'b1;
    for (int c = 0; c < 500; c++) begin
      step();
      m_axis_tready  = ($urandom_range(0, 3) != 0);
      link_up_i      = ($urandom_range(0, 9) != 0);
      idle_fill_en_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      if (exp_os_q.size() < 8 && $urandom_range(0, 3) == 0) push_pkt(1'b1, $urandom_range(1, 4));
      if (exp_dl_q.size() < 8 && $urandom_range(0, 3) == 0) push_pkt(1'b0, $urandom_range(1, 4));
    end
    step();
    m_axis_tready = 1'b1;
    link_up_i     = 1'b1;
    drain(3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
